// File: rtl/multi_mode_counter.sv
// Up/down counter with clamped load and wrap, saturate and one-shot modes.
// Registered terminal pulse so instances can be cascaded.
module multi_mode_counter #(
  parameter int COUNT_WIDTH = 4,
  parameter int COUNT_MIN   = 0,
  parameter int COUNT_MAX   = 9
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_up,
  input  logic                   i_load,
  input  logic [COUNT_WIDTH-1:0] i_load_value,
  input  logic [1:0]             i_mode,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_trig_out,
  output logic                   o_done
);

  localparam int W = COUNT_WIDTH;
  localparam logic [W-1:0] MIN_V = COUNT_MIN[W-1:0];
  localparam logic [W-1:0] MAX_V = COUNT_MAX[W-1:0];
  localparam logic [W-1:0] ONE   = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_RUN,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_count;
  logic           r_trig;

  logic [W:0]     w_lo_diff;
  logic [W:0]     w_hi_diff;
  logic [W-1:0]   w_load_clamped;
  logic           w_term;

  // Borrow bits give the range comparisons without constant-compare warnings.
  assign w_lo_diff = {1'b0, i_load_value} - {1'b0, MIN_V};
  assign w_hi_diff = {1'b0, MAX_V} - {1'b0, i_load_value};

  always_comb begin
    w_load_clamped = i_load_value;
    if (w_lo_diff[W])
      w_load_clamped = MIN_V;
    else if (w_hi_diff[W])
      w_load_clamped = MAX_V;
  end

  assign w_term = i_up ? (r_count == MAX_V)
                       : (r_count == MIN_V);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= MIN_V;
      r_trig  <= 1'b0;
      r_state <= S_RUN;
    end else begin
      r_trig <= 1'b0;
      if (i_load) begin
        r_count <= w_load_clamped;
        r_state <= S_RUN;
      end else if (i_enable && r_state == S_RUN) begin
        if (w_term) begin
          r_trig <= 1'b1;
          case (i_mode)
            2'b01: r_count <= r_count;
            2'b10: r_state <= S_DONE;
            default: r_count <= i_up ? MIN_V : MAX_V;
          endcase
        end else begin
          r_count <= i_up ? r_count + ONE
                          : r_count - ONE;
        end
      end
    end
  end

  assign o_count    = r_count;
  assign o_trig_out = r_trig;
  assign o_done     = (r_state == S_DONE);

endmodule
